// File: rtl/mux_rr_sel_if.sv
// Handshake bundle between N producer channels, the selector and one consumer.
// The "slave" modport is the selector's view and "master" is the environment's view.
interface mux_rr_sel_if #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_rr_sel.sv
// N-channel W-bit selector with valid/ready handshakes and a registered output stage.
// The channel is chosen either by the external select (mode=0) or by round-robin (mode=1).
module mux_rr_sel #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_sel_if.slave     bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state_r;
    logic [W-1:0]    out_data_r;
    logic [SELW-1:0] out_chan_r;
    logic [SELW-1:0] ptr_r;

    logic            load_ok_s;
    logic            fix_valid_s;
    logic            rr_valid_s;
    logic [SELW-1:0] rr_idx_s;
    logic            rr_hit_s;
    int              idx_s;
    logic [SELW-1:0] idx_sel_s;
    logic            grant_valid_s;
    logic [SELW-1:0] grant_idx_s;
    logic [W-1:0]    grant_data_s;
    logic            xfer_s;
    logic [N-1:0]    in_ready_s;

    // Output register may accept a new word when empty or when it is being drained.
    always_comb begin
        case (state_r)
            ST_EMPTY: load_ok_s = 1'b1;
            ST_FULL:  load_ok_s = bus.out_ready;
            default:  load_ok_s = 1'b0;
        endcase
    end

    // Fixed-select candidate; an out-of-range select never grants.
    always_comb begin
        fix_valid_s = 1'b0;
        if (int'(bus.sel) < N) begin
            fix_valid_s = bus.in_valid[bus.sel];
        end else begin
            fix_valid_s = 1'b0;
        end
    end

    // Round-robin candidate: first valid channel at or after ptr, wrapping at N.
    always_comb begin
        rr_valid_s = 1'b0;
        rr_idx_s   = '0;
        rr_hit_s   = 1'b0;
        idx_s      = 0;
        idx_sel_s  = '0;
        for (int i = 0; i < N; i++) begin
            idx_s      = int'(ptr_r) + i;
            idx_s      = (idx_s >= N) ? (idx_s - N) : idx_s;
            idx_sel_s  = SELW'(idx_s);
            rr_hit_s   = !rr_valid_s && bus.in_valid[idx_sel_s];
            rr_idx_s   = rr_hit_s ? idx_sel_s : rr_idx_s;
            rr_valid_s = rr_valid_s | rr_hit_s;
        end
    end

    // Pick the active grant source for the current mode.
    always_comb begin
        if (bus.mode) begin
            grant_valid_s = rr_valid_s;
            grant_idx_s   = rr_idx_s;
        end else begin
            grant_valid_s = fix_valid_s;
            grant_idx_s   = bus.sel;
        end
    end

    // Ready is one-hot on the granted channel; held low throughout reset.
    always_comb begin
        xfer_s       = rst_n & load_ok_s & grant_valid_s;
        in_ready_s   = '0;
        grant_data_s = '0;
        for (int k = 0; k < N; k++) begin
            in_ready_s[k] = xfer_s & (grant_idx_s == SELW'(k));
            grant_data_s  = (grant_idx_s == SELW'(k)) ? bus.in_data[k*W +: W] : grant_data_s;
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            out_data_r <= '0;
            out_chan_r <= '0;
            ptr_r      <= '0;
        end else if (xfer_s) begin
            state_r    <= ST_FULL;
            out_data_r <= grant_data_s;
            out_chan_r <= grant_idx_s;
            if (bus.mode) begin
                ptr_r <= (grant_idx_s == SELW'(N - 1)) ? '0
                         : grant_idx_s + {{(SELW-1){1'b0}}, 1'b1};
            end
        end else if ((state_r == ST_FULL) && bus.out_ready) begin
            state_r <= ST_EMPTY;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_chan  = out_chan_r;
    assign bus.out_valid = (state_r == ST_FULL);
endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed bench for mux_rr_sel (N=4, W=8): reset, fixed select, round-robin,
// backpressure and async reset while holding a word.
module tb_mux_rr_sel;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_rr_sel_if #(.N(4), .W(8), .SELW(2)) bus ();

    mux_rr_sel #(.N(4), .W(8), .SELW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_r;
        exp_r = 4'b0000;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h c=%0d expected v=0 d=00 c=0",
                     bus.out_valid, bus.out_data, bus.out_chan);
        end
        checks++;
        if (bus.in_ready !== exp_r) begin
            errors++;
            $display("FAIL reset_ready: got %b expected %b", bus.in_ready, exp_r);
        end
        bus.in_valid = 4'b0000;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== exp_r) begin
            errors++;
            $display("FAIL idle_ready: got %b expected %b", bus.in_ready, exp_r);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_fixed_sweep();
        logic [7:0] exp_d [4];
        logic [3:0] exp_r;
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.mode = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            exp_r = 4'b0001 << s;
            #1;
            checks++;
            if (bus.in_ready !== exp_r) begin
                errors++;
                $display("FAIL fix_ready sel=%0d: got %b expected %b", s, bus.in_ready, exp_r);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[s] || bus.out_chan !== 2'(s)) begin
                errors++;
                $display("FAIL fix_out sel=%0d: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d",
                         s, bus.out_valid, bus.out_data, bus.out_chan, exp_d[s], s);
            end
        end
    endtask

    task automatic test_rr_fair();
        logic [7:0] exp_d [4];
        logic [3:0] exp_r;
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_r = 4'b0001 << (i % 4);
            #1;
            checks++;
            if (bus.in_ready !== exp_r) begin
                errors++;
                $display("FAIL rr_ready cyc=%0d: got %b expected %b", i, bus.in_ready, exp_r);
            end
            @(negedge clk);
            checks++;
            if (bus.out_chan !== 2'(i % 4) || bus.out_data !== exp_d[i % 4]) begin
                errors++;
                $display("FAIL rr_out cyc=%0d: got c=%0d d=%h expected c=%0d d=%h",
                         i, bus.out_chan, bus.out_data, i % 4, exp_d[i % 4]);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_c [3];
        logic [3:0] exp_r [3];
        exp_c = '{2'd1, 2'd3, 2'd1};
        exp_r = '{4'b0010, 4'b1000, 4'b0010};
        bus.mode = 1'b1; bus.in_valid = 4'b1010; bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== exp_r[i]) begin
                errors++;
                $display("FAIL sparse_ready cyc=%0d: got %b expected %b", i, bus.in_ready, exp_r[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_chan !== exp_c[i]) begin
                errors++;
                $display("FAIL sparse_out cyc=%0d: got v=%b c=%0d expected v=1 c=%0d",
                         i, bus.out_valid, bus.out_chan, exp_c[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd2 || bus.out_data !== 8'h33) begin
            errors++;
            $display("FAIL bp_load: got v=%b c=%0d d=%h expected v=1 c=2 d=33",
                     bus.out_valid, bus.out_chan, bus.out_data);
        end
        bus.in_data[23:16] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready cyc=%0d: got %b expected 0000", i, bus.in_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd2 || bus.out_data !== 8'h33) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d: got v=%b c=%0d d=%h expected v=1 c=2 d=33",
                         i, bus.out_valid, bus.out_chan, bus.out_data);
            end
        end
        bus.in_data[23:16] = 8'h33;
        bus.out_ready = 1'b1;
        bus.sel = 2'd3;
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1000", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd3 || bus.out_data !== 8'h44) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b c=%0d d=%h expected v=1 c=3 d=44",
                     bus.out_valid, bus.out_chan, bus.out_data);
        end
    endtask

    task automatic test_fixed_invalid();
        bus.mode = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'b0001; bus.out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        bus.sel = 2'd2;
        bus.in_valid = 4'b1011;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL inv_ready: got %b expected 0000", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_chan !== 2'd0 || bus.out_data !== 8'h11) begin
            errors++;
            $display("FAIL inv_drain: got v=%b c=%0d d=%h expected v=0 c=0 d=11",
                     bus.out_valid, bus.out_chan, bus.out_data);
        end
        bus.in_valid = 4'b1111;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL inv_fix_ready: got %b expected 0100", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd2 || bus.out_data !== 8'h33) begin
            errors++;
            $display("FAIL inv_fix_out: got v=%b c=%0d d=%h expected v=1 c=2 d=33",
                     bus.out_valid, bus.out_chan, bus.out_data);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL async_rst: got v=%b d=%h c=%0d expected v=0 d=00 c=0",
                     bus.out_valid, bus.out_data, bus.out_chan);
        end
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst_ready: got %b expected 0000", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst_after: got v=%b r=%b expected v=0 r=0000",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid = 4'b1111;
        bus.mode = 1'b0;
        bus.sel = 2'd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_fixed_sweep();
        test_rr_fair();
        test_rr_sparse();
        test_backpressure();
        test_fixed_invalid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_sel.md
Name: mux_rr_sel

Overview:
- Parametrised N-channel, W-bit selector; successor to the 4:1 single-bit combinational mux.
- Adds per-channel valid/ready handshakes, a registered output stage, and two select modes: fixed (external select) and round-robin arbitration.
- Sits between multiple producer channels and a single consumer.
- Output carries the data and the index of the channel it came from.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel
SELW, 2, select/index width; must equal ceil(log2(N))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  N*W  packed channel data; channel k at [k*W+W-1 : k*W]
in_valid  input  N  channel k has data
in_ready  output  N  channel k transfer accepted this cycle (one-hot or zero)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel to pass when mode=0
out_data  output  W  registered selected data
out_chan  output  SELW  index of channel that supplied out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (rst_n low, asynchronous, any time) forces:
  - out_valid=0, out_data=0, out_chan=0
  - RR pointer ptr=0
  - in_ready=0 while reset is asserted
- Reset mid-transfer discards any held word. Nothing is replayed.
- Output stage has two states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load_ok = !out_valid | out_ready. This is combinational, so a word can be drained and a new one loaded in the same cycle.
- Grant (combinational):
  - mode=0: grant = sel if in_valid[sel], else no grant. Other channels never granted.
  - mode=0 with sel >= N: treated as no grant.
  - mode=1: first k with in_valid[k]=1, searching k = ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around).
- in_ready[k] = load_ok & grant valid & grant==k. At most one bit high.
- Transfer on channel k = in_valid[k] & in_ready[k]. On the next clk edge:
  - out_data <= channel k data
  - out_chan <= k
  - out_valid <= 1
- On the edge where out_valid & out_ready & no new transfer: out_valid <= 0. out_data and out_chan hold their old values.
- FULL & !out_ready: out_data, out_chan and out_valid hold; all in_ready=0 (backpressure).
- ptr update: after a transfer in mode=1, ptr <= (k==N-1) ? 0 : k+1. Transfers in mode=0 and cycles with no transfer leave ptr unchanged.
- mode or sel changes take effect on the next combinational grant. No pipeline flush is needed and a held output word is unaffected.
- Latency: input transfer to out_valid is 1 cycle. Sustained throughput is 1 word/cycle while out_ready=1.
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. It must not depend on in_data.
- Fairness: in mode=1, with all channels continuously valid, each channel is granted exactly once per N transfers.

Test Plan:
- Reset/idle:
  - Assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately (asynchronous).
  - After release with all in_valid=0 -> in_ready=0, out_valid stays 0.
- Fixed select, full sweep (the 4:1 check generalised; N=4, W=8):
  - Setup: mode=0, in_data ch0..3 = 0x11,0x22,0x33,0x44, all valid, out_ready=1.
  - Step sel 0..3 -> in_ready one-hot = 0001,0010,0100,1000; one cycle later out_data=0x11,0x22,0x33,0x44 with out_chan=0..3.
  - Mismatch message must print both expected and actual values.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and ptr wraps 3->0.
- Sparse round-robin: mode=1, ptr=0, in_valid=1010 -> grants ch1 then ch3, then ch1 again. in_ready never targets ch0 or ch2.
- Backpressure: FULL with out_chan=2, out_ready=0 for 3 cycles, sources valid -> in_ready=0000, out_data/out_chan stable. Then out_ready=1 -> drain and a new load in the same cycle, no bubble.
- Fixed select on invalid channel: mode=0, sel=2, in_valid=1011 -> no transfer, out_valid falls to 0 after drain. Setting in_valid[2]=1 -> ch2 data appears one cycle later.
